// File: rtl/coreaxitoahbl_wstrb_xfer_splitter_if.sv
// Beat-in / AHB-transfer-out bundle for the write-strobe transfer splitter.
interface coreaxitoahbl_wstrb_xfer_splitter_if #(
    parameter int unsigned AXI_STRBWIDTH = 8
);
    logic                     beatValid;
    logic                     beatReady;
    logic [31:0]              beatAddr;
    logic [AXI_STRBWIDTH-1:0] WSTRBIn;
    logic [3:0]               noValidBytes;
    logic                     xferValid;
    logic                     xferReady;
    logic [31:0]              xferAddr;
    logic [2:0]               xferSize;
    logic                     xferLast;
    logic                     strbErr;
    logic [15:0]              splitCount;

    modport master (
        output beatValid, beatAddr, WSTRBIn, noValidBytes, xferReady,
        input  beatReady, xferValid, xferAddr, xferSize, xferLast, strbErr, splitCount
    );

    modport slave (
        input  beatValid, beatAddr, WSTRBIn, noValidBytes, xferReady,
        output beatReady, xferValid, xferAddr, xferSize, xferLast, strbErr, splitCount
    );
endinterface

// File: rtl/coreaxitoahbl_wstrb_xfer_splitter.sv
// Splits one AXI write beat with contiguous strobes into naturally aligned AHB transfers.
// Optional beat-split statistics counter enabled by `define COREAXITOAHBL_SPLIT_STATS_EN.
module coreaxitoahbl_wstrb_xfer_splitter #(
    parameter int unsigned AXI_DWIDTH    = 64,
    parameter int unsigned AXI_STRBWIDTH = 8
) (
    input  logic HCLK,
    input  logic HRESETN,
    coreaxitoahbl_wstrb_xfer_splitter_if.slave bus
);

    localparam int unsigned OFFW = $clog2(AXI_DWIDTH / 8);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SPLIT = 1'b1;

    logic [0:0]      state, stateNext;
    logic [OFFW-1:0] offsetQ, offsetNext;
    logic [3:0]      remainingQ, remNext;
    logic [31:0]     baseAddrQ, baseNext;
    logic            xferValidQ, validNext;
    logic [31:0]     xferAddrQ, addrNext;
    logic [2:0]      xferSizeQ, sizeNext;
    logic            xferLastQ, lastNext;
    logic            strbErrQ, errNext;
    logic            beatReadyQ, readyNext;
    logic [OFFW-1:0] wOff;
    logic [3:0]      wRem;
    logic [2:0]      wK;
    logic [3:0]      curChunk;

    // Index of the lowest asserted strobe bit.
    function automatic logic [OFFW-1:0] lowIdx(input logic [AXI_STRBWIDTH-1:0] s);
        logic [OFFW-1:0] idx;
        idx = '0;
        for (int i = AXI_STRBWIDTH - 1; i >= 0; i--) begin
            if (s[i]) idx = OFFW'(i);
        end
        return idx;
    endfunction

    // log2 of the largest aligned power-of-two chunk that fits in the remaining bytes.
    function automatic logic [2:0] chunkLog2(input logic [OFFW-1:0] off, input logic [3:0] rem);
        logic [2:0] k;
        k = 3'd0;
        for (int i = 1; i <= int'(OFFW); i++) begin
            if ((32'(rem) >= (32'd1 << i)) && ((32'(off) & ((32'd1 << i) - 32'd1)) == 32'd0))
                k = 3'(i);
        end
        return k;
    endfunction

    assign curChunk = 4'd1 << xferSizeQ;

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) state <= IDLE;
        else          state <= stateNext;
    end

    always_comb begin
        stateNext  = state;
        offsetNext = offsetQ;
        remNext    = remainingQ;
        baseNext   = baseAddrQ;
        validNext  = xferValidQ;
        addrNext   = xferAddrQ;
        sizeNext   = xferSizeQ;
        lastNext   = xferLastQ;
        errNext    = 1'b0;
        readyNext  = beatReadyQ;
        wOff       = offsetQ;
        wRem       = remainingQ;
        wK         = 3'd0;
        if (state == IDLE) begin
            validNext = 1'b0;
            lastNext  = 1'b0;
            readyNext = 1'b1;
            if (bus.beatValid && beatReadyQ) begin
                if (bus.noValidBytes == 4'd0) begin
                    // Zero count with live strobes means the strobes were not contiguous.
                    errNext = |bus.WSTRBIn;
                end else begin
                    wOff       = lowIdx(bus.WSTRBIn);
                    wRem       = bus.noValidBytes;
                    wK         = chunkLog2(wOff, wRem);
                    offsetNext = wOff;
                    remNext    = wRem;
                    baseNext   = bus.beatAddr;
                    validNext  = 1'b1;
                    addrNext   = bus.beatAddr + 32'(wOff);
                    sizeNext   = wK;
                    lastNext   = ((4'd1 << wK) == wRem);
                    readyNext  = 1'b0;
                    stateNext  = SPLIT;
                end
            end
        end else begin
            readyNext = 1'b0;
            if (bus.xferReady) begin
                if (xferLastQ) begin
                    stateNext = IDLE;
                    validNext = 1'b0;
                    lastNext  = 1'b0;
                    readyNext = 1'b1;
                end else begin
                    wOff       = offsetQ + OFFW'(curChunk);
                    wRem       = remainingQ - curChunk;
                    wK         = chunkLog2(wOff, wRem);
                    offsetNext = wOff;
                    remNext    = wRem;
                    addrNext   = baseAddrQ + 32'(wOff);
                    sizeNext   = wK;
                    lastNext   = ((4'd1 << wK) == wRem);
                end
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            offsetQ    <= '0;
            remainingQ <= '0;
            baseAddrQ  <= '0;
            xferValidQ <= 1'b0;
            xferAddrQ  <= '0;
            xferSizeQ  <= '0;
            xferLastQ  <= 1'b0;
            strbErrQ   <= 1'b0;
            beatReadyQ <= 1'b1;
        end else begin
            offsetQ    <= offsetNext;
            remainingQ <= remNext;
            baseAddrQ  <= baseNext;
            xferValidQ <= validNext;
            xferAddrQ  <= addrNext;
            xferSizeQ  <= sizeNext;
            xferLastQ  <= lastNext;
            strbErrQ   <= errNext;
            beatReadyQ <= readyNext;
        end
    end

    assign bus.beatReady = beatReadyQ;
    assign bus.xferValid = xferValidQ;
    assign bus.xferAddr  = xferAddrQ;
    assign bus.xferSize  = xferSizeQ;
    assign bus.xferLast  = xferLastQ;
    assign bus.strbErr   = strbErrQ;

`ifdef COREAXITOAHBL_SPLIT_STATS_EN
    logic        splitIncr;
    logic [15:0] splitCountQ;

    // A beat counts as split when its first chunk is smaller than its byte count.
    assign splitIncr = (state == IDLE) && bus.beatValid && beatReadyQ &&
                       (bus.noValidBytes != 4'd0) && ((4'd1 << wK) < bus.noValidBytes);

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN)                                splitCountQ <= '0;
        else if (splitIncr && splitCountQ != 16'hFFFF) splitCountQ <= splitCountQ + 16'd1;
    end

    assign bus.splitCount = splitCountQ;
`else
    assign bus.splitCount = '0;
`endif

endmodule

// File: tb/tb_coreaxitoahbl_wstrb_xfer_splitter.sv
// Bench for the write-strobe splitter: directed literal cases plus random beats against a queue model.
module tb_coreaxitoahbl_wstrb_xfer_splitter;

    localparam int unsigned STRBW = 8;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  size;
        logic        last;
    } xfer_t;

    logic HCLK = 1'b0;
    logic HRESETN = 1'b0;
    always #5 HCLK = ~HCLK;

    coreaxitoahbl_wstrb_xfer_splitter_if #(.AXI_STRBWIDTH(STRBW)) bus ();

    coreaxitoahbl_wstrb_xfer_splitter #(
        .AXI_DWIDTH   (64),
        .AXI_STRBWIDTH(STRBW)
    ) u_dut (
        .HCLK   (HCLK),
        .HRESETN(HRESETN),
        .bus    (bus)
    );

    xfer_t expQ[$];
    int    checks = 0;
    int    errors = 0;
    int    readyMode = 2;
    logic  expErr = 1'b0;
    int    expSplit = 0;
    logic  stallPrev = 1'b0;
    xfer_t prevX;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowBit(input logic [STRBW-1:0] s);
        int lo;
        lo = 0;
        for (int i = int'(STRBW) - 1; i >= 0; i--) if (s[i]) lo = i;
        return lo;
    endfunction

    // Byte count for contiguous strobes, 0 for empty or holed strobes.
    function automatic int nBytes(input logic [STRBW-1:0] s);
        int t;
        if (s == '0) return 0;
        t = int'(s) >> lowBit(s);
        if ((t & (t + 1)) != 0) return 0;
        return $countones(s);
    endfunction

    // Greedy aligned power-of-two decomposition of [off, off+n).
    function automatic void expand(input logic [31:0] a, input logic [STRBW-1:0] s, input int n);
        int off;
        int rem;
        int c;
        int k;
        off = lowBit(s);
        rem = n;
        while (rem > 0) begin
            c = int'(STRBW);
            while (c > rem || (off % c) != 0) c = c / 2;
            k = 0;
            while ((1 << k) < c) k++;
            expQ.push_back('{a + 32'(off), 3'(k), (c == rem)});
            off += c;
            rem -= c;
        end
    endfunction

    // Per-cycle compare against the model, then advance the model for the coming edge.
    always @(negedge HCLK) begin
        if (!HRESETN) begin
            chk("rstXferValid", 32'(bus.xferValid), 32'd0);
            chk("rstXferLast", 32'(bus.xferLast), 32'd0);
            chk("rstXferAddr", bus.xferAddr, 32'd0);
            chk("rstXferSize", 32'(bus.xferSize), 32'd0);
            chk("rstStrbErr", 32'(bus.strbErr), 32'd0);
            chk("rstSplitCount", 32'(bus.splitCount), 32'd0);
            expQ.delete();
            expErr    = 1'b0;
            expSplit  = 0;
            stallPrev = 1'b0;
        end else begin
            chk("beatReady", 32'(bus.beatReady), 32'(expQ.size() == 0));
            chk("xferValid", 32'(bus.xferValid), 32'(expQ.size() != 0));
            chk("strbErr", 32'(bus.strbErr), 32'(expErr));
            chk("splitCount", 32'(bus.splitCount), 32'(expSplit));
            if (expQ.size() != 0 && bus.xferValid) begin
                chk("xferAddr", bus.xferAddr, expQ[0].addr);
                chk("xferSize", 32'(bus.xferSize), 32'(expQ[0].size));
                chk("xferLast", 32'(bus.xferLast), 32'(expQ[0].last));
            end
            if (stallPrev) begin
                chk("holdAddr", bus.xferAddr, prevX.addr);
                chk("holdSize", 32'(bus.xferSize), 32'(prevX.size));
            end
            stallPrev = bus.xferValid && !bus.xferReady;
            prevX     = '{bus.xferAddr, bus.xferSize, bus.xferLast};
            expErr    = 1'b0;
            if (expQ.size() == 0) begin
                if (bus.beatValid) begin
                    if (bus.noValidBytes == 4'd0) begin
                        expErr = (bus.WSTRBIn != '0);
                    end else begin
                        expand(bus.beatAddr, bus.WSTRBIn, int'(bus.noValidBytes));
`ifdef COREAXITOAHBL_SPLIT_STATS_EN
                        if (expQ.size() > 1 && expSplit < 16'hFFFF) expSplit++;
`endif
                    end
                end
            end else if (bus.xferReady) begin
                void'(expQ.pop_front());
            end
        end
    end

    // xferReady: 0 random, 1 held low, 2 held high.
    always @(posedge HCLK) begin
        #1;
        if (readyMode == 2)      bus.xferReady = 1'b1;
        else if (readyMode == 1) bus.xferReady = 1'b0;
        else                     bus.xferReady = 1'($urandom);
    end

    task automatic sendBeat(input logic [31:0] a, input logic [STRBW-1:0] s);
        logic ok;
        @(posedge HCLK);
        #1;
        bus.beatValid    = 1'b1;
        bus.beatAddr     = a;
        bus.WSTRBIn      = s;
        bus.noValidBytes = 4'(nBytes(s));
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge HCLK);
            if (bus.beatReady) begin
                ok = 1'b1;
                break;
            end
        end
        chk("beatAcceptTimeout", 32'(ok), 32'd1);
        @(posedge HCLK);
        #1;
        bus.beatValid = 1'b0;
    endtask

    task automatic expectXfer(input logic [31:0] a, input logic [2:0] sz, input logic last);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge HCLK);
            if (bus.xferValid && bus.xferReady) begin
                ok = 1'b1;
                break;
            end
        end
        chk("xferTimeout", 32'(ok), 32'd1);
        chk("litAddr", bus.xferAddr, a);
        chk("litSize", 32'(bus.xferSize), 32'(sz));
        chk("litLast", 32'(bus.xferLast), 32'(last));
    endtask

    initial begin
        logic [STRBW-1:0] s;
        int               t;
        int               st;
        int               ln;
        logic             drained;

        bus.beatValid    = 1'b0;
        bus.beatAddr     = '0;
        bus.WSTRBIn      = '0;
        bus.noValidBytes = '0;
        bus.xferReady    = 1'b1;
        repeat (3) @(posedge HCLK);
        #1 HRESETN = 1'b1;
        @(negedge HCLK);
        chk("postRstBeatReady", 32'(bus.beatReady), 32'd1);

        // Full doubleword beat
        sendBeat(32'h1000, 8'hFF);
        expectXfer(32'h1000, 3'd3, 1'b1);

        // Six bytes from offset 1
        sendBeat(32'h1000, 8'b0111_1110);
        expectXfer(32'h1001, 3'd0, 1'b0);
        expectXfer(32'h1002, 3'd1, 1'b0);
        expectXfer(32'h1004, 3'd1, 1'b0);
        expectXfer(32'h1006, 3'd0, 1'b1);
`ifdef COREAXITOAHBL_SPLIT_STATS_EN
        chk("litSplitCount", 32'(bus.splitCount), 32'd1);
`else
        chk("litSplitCount", 32'(bus.splitCount), 32'd0);
`endif

        // Three bytes, with a 5-cycle stall on the halfword
        sendBeat(32'h1000, 8'b0000_1110);
        expectXfer(32'h1001, 3'd0, 1'b0);
        readyMode = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge HCLK);
            chk("stallValid", 32'(bus.xferValid), 32'd1);
            chk("stallAddr", bus.xferAddr, 32'h1002);
            chk("stallSize", 32'(bus.xferSize), 32'd1);
        end
        readyMode = 2;
        expectXfer(32'h1002, 3'd1, 1'b1);

        // Holed strobes pulse strbErr; empty strobes are silent
        sendBeat(32'h1000, 8'b1000_0001);
        @(negedge HCLK);
        chk("errPulse", 32'(bus.strbErr), 32'd1);
        chk("errNoXfer", 32'(bus.xferValid), 32'd0);
        @(negedge HCLK);
        chk("errOneCycle", 32'(bus.strbErr), 32'd0);
        sendBeat(32'h1000, 8'h00);
        @(negedge HCLK);
        chk("zeroNoErr", 32'(bus.strbErr), 32'd0);
        chk("zeroNoXfer", 32'(bus.xferValid), 32'd0);

        // Reset in the middle of a split
        readyMode = 1;
        sendBeat(32'h2000, 8'h7F);
        @(negedge HCLK);
        chk("midValid", 32'(bus.xferValid), 32'd1);
        chk("midAddr", bus.xferAddr, 32'h2000);
        chk("midSize", 32'(bus.xferSize), 32'd2);
        @(posedge HCLK);
        #1 HRESETN = 1'b0;
        #1;
        chk("asyncRstValid", 32'(bus.xferValid), 32'd0);
        @(posedge HCLK);
        #1 HRESETN = 1'b1;
        @(negedge HCLK);
        chk("relBeatReady", 32'(bus.beatReady), 32'd1);
        chk("relValid", 32'(bus.xferValid), 32'd0);

        // Random beats under random backpressure
        readyMode = 0;
        for (int b = 0; b < 300; b++) begin
            repeat ($urandom % 3) @(posedge HCLK);
            t = int'($urandom % 20);
            if (t < 2) begin
                s = '0;
            end else if (t < 5) begin
                s = STRBW'($urandom);
            end else begin
                st = int'($urandom % STRBW);
                ln = 1 + int'($urandom % (STRBW - st));
                s  = STRBW'(((1 << ln) - 1) << st);
            end
            sendBeat($urandom & 32'hFFFF_FFF8, s);
        end

        drained = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge HCLK);
            if (expQ.size() == 0) begin
                drained = 1'b1;
                break;
            end
        end
        chk("drainTimeout", 32'(drained), 32'd1);
        @(negedge HCLK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/coreaxitoahbl_wstrb_xfer_splitter.md
COREAXITOAHBL_WSTRB_XFER_SPLITTER -- requirements
Module: coreaxitoahbl_wstrb_xfer_splitter

Interface
REQ-001 AXI_DWIDTH, 64, AXI data width; legal values 32 or 64.
REQ-002 AXI_STRBWIDTH, 8, strobe width; 4 when AXI_DWIDTH=32, 8 when 64.
REQ-003 HCLK  input  1  single clock; all state updates on its rising edge.
REQ-004 HRESETN  input  1  asynchronous, active-low reset.
REQ-005 beatValid  input  1  write beat available.
REQ-006 beatReady  output  1  splitter accepts the beat this cycle.
REQ-007 beatAddr  input  32  beat base address, aligned to AXI_STRBWIDTH bytes.
REQ-008 WSTRBIn  input  AXI_STRBWIDTH  write strobes of the beat.
REQ-009 noValidBytes  input  4  strobe population count from the popcount ROM; 0 for zero or non-contiguous strobes.
REQ-010 xferValid  output  1  AHB transfer request valid.
REQ-011 xferReady  input  1  AHB master accepts the transfer.
REQ-012 xferAddr  output  32  byte address of the transfer (HADDR).
REQ-013 xferSize  output  3  HSIZE: 0 byte, 1 halfword, 2 word, 3 doubleword.
REQ-014 xferLast  output  1  final transfer of the current beat.
REQ-015 strbErr  output  1  one-cycle pulse when a beat has non-zero, non-contiguous strobes.
REQ-016 splitCount  output  16  count of beats needing more than one transfer.

Function
REQ-017 The FSM SHALL have two states: IDLE and SPLIT.
REQ-018 In IDLE, beatReady SHALL be 1 and xferValid SHALL be 0. In SPLIT, beatReady SHALL be 0.
REQ-019 Handshake on beatValid&&beatReady with noValidBytes=0 SHALL consume the beat, stay in IDLE and emit no transfer.
REQ-020 That same handshake SHALL pulse strbErr the next cycle when WSTRBIn!=0; an all-zero WSTRBIn SHALL be consumed silently.
REQ-021 Handshake with noValidBytes!=0 SHALL latch offset (index of the lowest set WSTRBIn bit), remaining=noValidBytes and beatAddr, then enter SPLIT.
REQ-022 xferValid SHALL assert the cycle after beat acceptance; latency is 1 cycle.
REQ-023 In SPLIT, chunk=2^k SHALL be the largest power of two with 2^k<=remaining, offset mod 2^k==0 and 2^k<=AXI_STRBWIDTH.
REQ-024 xferSize SHALL be k and xferAddr SHALL be beatAddr+offset.
REQ-025 Outputs SHALL be registered and held stable while xferValid&&!xferReady.
REQ-026 On xferValid&&xferReady, offset SHALL increase by chunk and remaining SHALL decrease by chunk.
REQ-027 xferLast SHALL be 1 exactly when chunk==remaining; on that handshake the FSM SHALL return to IDLE.
REQ-028 No back-to-back overlap: the next beat SHALL be accepted no earlier than the cycle after the last transfer handshake.
REQ-029 offset arithmetic SHALL stay within log2(AXI_STRBWIDTH) bits and SHALL never wrap within a beat.

Reset
REQ-030 Asserting HRESETN low, including mid-SPLIT, SHALL immediately return the FSM to IDLE and abandon any partial beat.
REQ-031 Reset values: xferValid=0, xferLast=0, xferAddr=0, xferSize=0, strbErr=0, splitCount=0; beatReady=1 after reset release.

Configuration
REQ-032 Macro COREAXITOAHBL_SPLIT_STATS_EN defined: splitCount SHALL increment, saturating at 0xFFFF, on each beat accepted with chunk<noValidBytes at entry.
REQ-033 Macro undefined: splitCount SHALL be tied to 0 and no counter logic SHALL be built.

Verification
REQ-034 64-bit, beatAddr=0x1000, WSTRB=8'hFF, n=8 -> one transfer: addr 0x1000, size 3, last=1.
REQ-035 WSTRB=8'b00001110, n=3 -> byte @0x1001, then halfword @0x1002 with last=1.
REQ-036 WSTRB=8'b01111110, n=6 -> byte@0x1001, half@0x1002, half@0x1004, byte@0x1006 last; with STATS_EN, splitCount=1.
REQ-037 WSTRB=8'b10000001, n=0 -> beat consumed, strbErr pulses one cycle, no xferValid; WSTRB=0 -> no strbErr.
REQ-038 xferReady held low 5 cycles on the 0x1002 transfer -> addr and size held stable; HRESETN low mid-SPLIT -> xferValid=0, beatReady=1 after reset release.
